// File: rtl/packet_filter_pkg.sv
// Shared definitions for the packet filter egress path: descriptor layout,
// egress reader FSM states and length/parity helpers.
package packet_filter_pkg;

    localparam int DESC_WIDTH      = 20;
    localparam int DESC_DROP_BIT   = 19;
    localparam int DESC_LEN_MSB    = 10;
    localparam int DESC_LEN_LSB    = 0;
    localparam int LEN_WIDTH       = DESC_LEN_MSB - DESC_LEN_LSB + 1;
    localparam int MAX_LEN_DEFAULT = 759;

    localparam int PAYLOAD_WIDTH   = 16;
    localparam int PARITY_WIDTH    = 4;
    localparam int FIFO_WORD_WIDTH = PAYLOAD_WIDTH + PARITY_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DROP,
        ST_FLUSH
    } egress_state_e;

    function automatic logic len_is_legal(input logic [LEN_WIDTH-1:0] len,
                                          input int unsigned max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

    // Even parity: each parity bit equals the XOR of its payload nibble.
    function automatic logic [PARITY_WIDTH-1:0] nibble_parity(input logic [PAYLOAD_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        for (int i = 0; i < PARITY_WIDTH; i++) begin
            p[i] = ^d[i*4 +: 4];
        end
        return p;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry in-order output buffer with registered outputs; the head entry is
// held unchanged until it is consumed.
module axis_skid_buffer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [1:0]       used;
    logic             pop;
    logic [1:0]       wr_idx;

    assign pop    = (used != 2'd0) && out_ready;
    assign wr_idx = used - {1'b0, pop};

    // A pop shifts slot1 forward; a same-cycle push into slot0 overrides that shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            used  <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop) begin
                slot0 <= slot1;
            end
            if (in_valid) begin
                if (wr_idx == 2'd0) begin
                    slot0 <= in_data;
                end else begin
                    slot1 <= in_data;
                end
            end
            used <= used + {1'b0, in_valid} - {1'b0, pop};
        end
    end

    assign out_valid = (used != 2'd0);
    assign out_data  = out_valid ? slot0 : '0;
    assign count     = used;

endmodule

// File: rtl/egress_reader.sv
// Reads descriptor-described frames out of the frame FIFO onto an AXI-stream
// egress port; optional per-nibble parity checking under EGRESS_READER_PARITY_EN.
module egress_reader
    import packet_filter_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_LEN    = MAX_LEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic [DESC_WIDTH-1:0]      desc_data,
    output logic                       frame_ren,
    input  logic [FIFO_WORD_WIDTH-1:0] frame_rdata,
    input  logic                       frame_empty,
    input  logic [ADDR_WIDTH:0]        frame_rptr,
    output logic                       frame_rrst,
    output logic [ADDR_WIDTH:0]        frame_rst_rptr,
    output logic [PAYLOAD_WIDTH-1:0]   tdata,
    output logic                       tvalid,
    output logic                       tlast,
    input  logic                       tready,
    output logic                       parity_err,
    output logic                       len_err
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    egress_state_e          state;
    egress_state_e          next_state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [LEN_WIDTH-1:0]   frame_len;
    logic                   rd_pending;
    logic                   rd_pending_last;
    logic                   desc_fire;
    logic                   desc_drop;
    logic                   desc_legal;
    logic [LEN_WIDTH-1:0]   desc_len;
    logic                   out_pop;
    logic                   has_credit;
    logic [1:0]             skid_count;
    logic [2:0]             slots_used;
    logic [PAYLOAD_WIDTH:0] skid_out;
    logic                   unused_desc_bits;

    assign desc_len         = desc_data[DESC_LEN_MSB:DESC_LEN_LSB];
    assign desc_drop        = desc_data[DESC_DROP_BIT];
    assign desc_legal       = len_is_legal(desc_len, MAX_LEN);
    assign desc_fire        = desc_valid && desc_ready;
    assign unused_desc_bits = ^desc_data[DESC_DROP_BIT-1:DESC_LEN_MSB+1];

    assign out_pop = tvalid && tready;

    // Reads already in flight occupy a slot; a beat leaving this cycle frees one.
    assign slots_used = {1'b0, skid_count} + {2'b00, rd_pending};
    assign has_credit = slots_used < (3'd2 + {2'b00, out_pop});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (desc_fire) begin
                    next_state = (desc_drop || !desc_legal) ? ST_DROP : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (frame_ren && (remaining == LEN_WIDTH'(1))) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_DROP: begin
                next_state = ST_IDLE;
            end
            ST_FLUSH: begin
                if (out_pop && tlast) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Reset is folded into desc_ready because IDLE is also the reset state.
    always_comb begin
        desc_ready     = 1'b0;
        frame_ren      = 1'b0;
        frame_rrst     = 1'b0;
        frame_rst_rptr = '0;
        case (state)
            ST_IDLE: begin
                desc_ready = en && !reset;
            end
            ST_STREAM: begin
                frame_ren = (remaining != '0) && !frame_empty && has_credit;
            end
            ST_DROP: begin
                frame_rrst     = 1'b1;
                frame_rst_rptr = frame_rptr + PTR_W'(frame_len);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining       <= '0;
            frame_len       <= '0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
            len_err         <= 1'b0;
        end else begin
            if (desc_fire) begin
                frame_len <= desc_len;
                remaining <= (desc_drop || !desc_legal) ? '0 : desc_len;
                if (!desc_legal) begin
                    len_err <= 1'b1;
                end
            end else if (frame_ren) begin
                remaining <= remaining - LEN_WIDTH'(1);
            end
            rd_pending      <= frame_ren;
            rd_pending_last <= frame_ren && (remaining == LEN_WIDTH'(1));
        end
    end

    axis_skid_buffer #(
        .WIDTH(PAYLOAD_WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rd_pending),
        .in_data  ({rd_pending_last, frame_rdata[PAYLOAD_WIDTH-1:0]}),
        .out_ready(tready),
        .out_valid(tvalid),
        .out_data (skid_out),
        .count    (skid_count)
    );

    assign tdata = skid_out[PAYLOAD_WIDTH-1:0];
    assign tlast = skid_out[PAYLOAD_WIDTH];

`ifdef EGRESS_READER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (rd_pending &&
                     (frame_rdata[FIFO_WORD_WIDTH-1:PAYLOAD_WIDTH] !=
                      nibble_parity(frame_rdata[PAYLOAD_WIDTH-1:0]))) begin
            parity_err <= 1'b1;
        end
    end
`else
    logic unused_parity_bits;
    assign unused_parity_bits = ^frame_rdata[FIFO_WORD_WIDTH-1:PAYLOAD_WIDTH];
    assign parity_err         = 1'b0;
`endif

endmodule

// File: doc/egress_reader.md
EGRESS_READER -- requirements
Module: egress_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, frame FIFO address width (pointers are ADDR_WIDTH+1 bits).
REQ-002 SHALL have parameter MAX_LEN, default 759, largest legal frame length in 16-bit half-words.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  enables new descriptor acceptance.
REQ-006 desc_valid / desc_ready  in / out  1 / 1  sideband descriptor handshake.
REQ-007 desc_data  in  20  [19]=drop, [18:11]=reserved, [10:0]=length in half-words.
REQ-008 frame_ren  out  1  frame FIFO read enable.
REQ-009 frame_rdata  in  20  FIFO word: [15:0] payload, [19:16] parity.
REQ-010 frame_empty  in  1  frame FIFO empty.
REQ-011 frame_rptr  in  ADDR_WIDTH+1  current FIFO read pointer.
REQ-012 frame_rrst / frame_rst_rptr  out / out  1 / ADDR_WIDTH+1  read-pointer load strobe and value.
REQ-013 tdata / tvalid / tlast  out  16 / 1 / 1  egress AXI-stream source.
REQ-014 tready  in  1  egress AXI-stream sink ready.
REQ-015 parity_err  out  1  sticky parity error flag.
REQ-016 len_err  out  1  sticky illegal-length flag.

Function
REQ-017 SHALL run FSM IDLE, STREAM, DROP, FLUSH.
REQ-018 IDLE: desc_ready=en; handshake with drop=0 and 1<=length<=MAX_LEN -> STREAM, remaining count := length.
REQ-019 IDLE: handshake with drop=1 -> DROP; with length=0 or >MAX_LEN -> DROP and set len_err.
REQ-020 DROP: frame_rrst=1 for exactly one cycle with frame_rst_rptr=frame_rptr+length, modulo 2^(ADDR_WIDTH+1); then IDLE.
REQ-021 FIFO read latency is one cycle: frame_rdata is valid the cycle after frame_ren.
REQ-022 STREAM: frame_ren only when remaining>0, frame_empty=0, and a 2-entry output skid buffer has a free slot counting in-flight reads.
REQ-023 The skid buffer SHALL deliver payload in order; tdata/tvalid/tlast SHALL be stable while tvalid=1 and tready=0.
REQ-024 tlast SHALL be 1 exactly on the length-th half-word of a frame.
REQ-025 STREAM -> FLUSH after the last read issues; FLUSH -> IDLE when the tlast beat is accepted.
REQ-026 Throughput SHALL be one half-word per cycle with tready=1 and a non-empty FIFO; first tvalid two cycles after the descriptor handshake.
REQ-027 frame_empty mid-frame SHALL stall reads without dropping or duplicating words.
REQ-028 desc_ready SHALL be 0 outside IDLE; deasserting en mid-frame SHALL NOT abort the current frame.
REQ-029 Pointer wrap-around SHALL be handled by modular arithmetic only.

Reset
REQ-030 Reset SHALL force IDLE, empty skid buffer, and remaining=0.
REQ-031 During reset all outputs SHALL be 0 (desc_ready, frame_ren, frame_rrst, frame_rst_rptr, tdata, tvalid, tlast, parity_err, len_err).
REQ-032 Reset mid-frame SHALL discard partial output with no tlast emitted.

Configuration
REQ-033 With EGRESS_READER_PARITY_EN defined: each payload beat SHALL check frame_rdata[19:16] as even parity per payload nibble; a mismatch sets parity_err.
REQ-034 Without EGRESS_READER_PARITY_EN: parity_err SHALL be tied 0 and frame_rdata[19:16] ignored.

Structure
REQ-035 The descriptor bit positions, the FSM state enum, and the MAX_LEN default SHALL live in the shared packet_filter package.
REQ-036 The skid buffer SHALL be a sub-module, axis_skid_buffer.

Verification
REQ-037 Descriptor len=4, drop=0, FIFO preloaded 0x0001..0x0004, tready=1 -> four beats on consecutive cycles, tlast on 0x0004.
REQ-038 Descriptor drop=1 len=10 with frame_rptr=4090 (12-bit) -> frame_rrst single pulse, rst_rptr=4; no tvalid.
REQ-039 len=3 with tready toggling 1,0,0,1... -> data held stable while stalled; 3 beats accepted in order, single tlast.
REQ-040 len=0 -> len_err=1, DROP pulse with rst_rptr=frame_rptr, return to IDLE.
REQ-041 Parity macro on, word 3 of 5 has corrupted [19:16] -> parity_err=1 from that beat onward; frame still completes with 5 beats.
REQ-042 Reset asserted after beat 2 of a len=6 frame -> all outputs 0; next descriptor is accepted normally.
